unreflector: RTL and testbench

UNREFLECTOR -- requirements
Module: unreflector

---
 rtl/unreflector_if.sv | 29 ++
 rtl/unreflector.sv | 128 ++++++++++++
 tb/tb_unreflector.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/unreflector_if.sv
// Bundle between the CORDIC front end, the core result path and the unreflector.
// The master drives sample flags and core results; the slave returns corrected results and FIFO status.
interface unreflector_if #(
  parameter int B     = 14,
  parameter int DEPTH = 16
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             reflect_in;
  logic             has_angle_in;
  logic             core_valid;
  logic [2*B-1:0]   core_data;
  logic             out_valid;
  logic [2*B-1:0]   out_data;
  logic [OCC_W-1:0] occupancy;
  logic             overflow;
  logic             underflow;

  modport master (
    output in_valid, reflect_in, has_angle_in, core_valid, core_data,
    input  out_valid, out_data, occupancy, overflow, underflow
  );

  modport slave (
    input  in_valid, reflect_in, has_angle_in, core_valid, core_data,
    output out_valid, out_data, occupancy, overflow, underflow
  );
endinterface

// File: rtl/unreflector.sv
// Undoes the pre-core origin reflection of CORDIC samples using a FIFO of per-sample flags; 1-cycle latency.
// No backpressure: pushes into a full FIFO are dropped (sticky overflow), pops from empty act as reflect=0 (sticky underflow).
module unreflector #(
  parameter int B     = 14,
  parameter int N     = 13,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  unreflector_if.slave bus
);
  localparam int             ANG      = N + (N % 2);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [B-1:0]   MOST_NEG = {1'b1, {(B-1){1'b0}}};
  localparam logic [B-1:0]   MOST_POS = {1'b0, {(B-1){1'b1}}};

  logic [1:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_overflow;
  logic           r_underflow;
  logic           r_out_valid;
  logic [2*B-1:0] r_out_data;

  logic           w_push;
  logic           w_pop;
  logic           w_empty;
  logic           w_full;
  logic [1:0]     w_in_pair;
  logic [1:0]     w_pair;
  logic           w_do_wr;
  logic           w_do_rd;
  logic           w_set_ovf;
  logic           w_set_unf;
  logic [B-1:0]   w_x;
  logic [B-1:0]   w_y;
  logic [2*B-1:0] w_fixed;

  function automatic logic [B-1:0] neg_sat(input logic [B-1:0] v);
    if (v == MOST_NEG) return MOST_POS;
    return -v;
  endfunction

  assign w_push    = bus.in_valid;
  assign w_pop     = bus.core_valid;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_in_pair = {bus.reflect_in, bus.has_angle_in};

  // A pop from an empty FIFO with a same-cycle push consumes the incoming pair directly.
  always_comb begin
    w_pair    = 2'b00;
    w_do_wr   = 1'b0;
    w_do_rd   = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (w_pop) begin
      if (!w_empty) begin
        w_pair  = r_mem[r_rd_ptr];
        w_do_rd = 1'b1;
      end else if (w_push) begin
        w_pair = w_in_pair;
      end else begin
        w_set_unf = 1'b1;
      end
    end
    if (w_push && !(w_pop && w_empty)) begin
      if (w_full && !w_pop) begin
        w_set_ovf = 1'b1;
      end else begin
        w_do_wr = 1'b1;
      end
    end
  end

  assign w_x = bus.core_data[2*B-1:B];
  assign w_y = bus.core_data[B-1:0];

  // Angle results get +pi (MSB flip of the binary angle); rotation results negate both halves.
  always_comb begin
    w_fixed = bus.core_data;
    if (w_pair[1]) begin
      if (w_pair[0]) begin
        w_fixed[ANG-1] = ~bus.core_data[ANG-1];
      end else begin
        w_fixed = {neg_sat(w_x), neg_sat(w_y)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_do_wr) begin
      r_mem[r_wr_ptr] <= w_in_pair;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_set_ovf) r_overflow  <= 1'b1;
      if (w_set_unf) r_underflow <= 1'b1;
      r_out_valid <= w_pop;
      if (w_pop) r_out_data <= w_fixed;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.occupancy = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_unreflector.sv
// Directed bench for unreflector: a flag-queue model predicts each correction into a scoreboard queue.
module tb_unreflector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unreflector_if #(.B(14), .DEPTH(16)) bus ();
  unreflector #(.B(14), .N(13), .DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_vec = 0;
  int          n_err = 0;
  logic [1:0]  mq[$];
  logic [27:0] sq[$];
  logic        m_ovf  = 1'b0;
  logic        m_unf  = 1'b0;
  logic [27:0] m_hold = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] ref_fix(input logic [1:0] p, input logic [27:0] cd);
    int xi;
    int yi;
    logic [13:0] ang;
    if (!p[1]) return cd;
    if (p[0]) begin
      ang = cd[13:0] + 14'd8192;
      return {cd[27:14], ang};
    end
    xi = -int'($signed(cd[27:14]));
    yi = -int'($signed(cd[13:0]));
    if (xi > 8191) xi = 8191;
    if (yi > 8191) yi = 8191;
    return {14'(xi), 14'(yi)};
  endfunction

  task automatic step(input logic push, input logic r, input logic a,
                      input logic pop, input logic [27:0] cd);
    logic [1:0]  pair;
    logic        took;
    logic [27:0] exp;
    @(negedge clk);
    bus.in_valid     = push;
    bus.reflect_in   = r;
    bus.has_angle_in = a;
    bus.core_valid   = pop;
    bus.core_data    = cd;
    took = 1'b0;
    if (pop) begin
      if (mq.size() > 0) begin
        pair = mq.pop_front();
      end else if (push) begin
        pair = {r, a};
        took = 1'b1;
      end else begin
        pair  = 2'b00;
        m_unf = 1'b1;
      end
      sq.push_back(ref_fix(pair, cd));
    end
    if (push && !took) begin
      if (mq.size() < 16) mq.push_back({r, a});
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.core_valid = 1'b0;
    if (pop) begin
      chk("out_valid_hi", 32'(bus.out_valid), 32'd1);
      exp = sq.pop_front();
      chk("out_data", 32'(bus.out_data), 32'(exp));
      m_hold = exp;
    end else begin
      chk("out_valid_lo", 32'(bus.out_valid), 32'd0);
      chk("out_data_hold", 32'(bus.out_data), 32'(m_hold));
    end
    chk("occupancy", 32'(bus.occupancy), 32'(mq.size()));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.in_valid   = 1'b1;
    bus.reflect_in = 1'b1;
    bus.core_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_underflow", 32'(bus.underflow), 32'd0);
    @(negedge clk);
    rst            = 1'b0;
    bus.in_valid   = 1'b0;
    bus.core_valid = 1'b0;
    mq.delete();
    sq.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_hold = '0;
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.reflect_in   = 1'b0;
    bus.has_angle_in = 1'b0;
    bus.core_valid   = 1'b0;
    bus.core_data    = '0;
    do_reset();

    // Rotation reflect: x=100, y=-5 comes back as x=-100, y=5.
    step(1, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, {14'd100, 14'h3FFB});
    chk("rot_reflect", 32'(bus.out_data), 32'({14'h3F9C, 14'h0005}));

    // Angle reflect: +pi on the angle field, upper bits untouched.
    step(1, 1, 1, 0, '0);
    step(0, 0, 0, 1, {14'h1234, 14'h0100});
    chk("ang_reflect", 32'(bus.out_data), 32'({14'h1234, 14'h2100}));

    // Saturation of the most negative coordinate, on each half.
    step(1, 1, 0, 0, '0);
    step(0, 0, 0, 1, {14'h2000, 14'h0000});
    chk("sat_x", 32'(bus.out_data), 32'({14'h1FFF, 14'h0000}));
    step(1, 1, 0, 0, '0);
    step(0, 0, 0, 1, {14'h0001, 14'h2000});
    chk("sat_y", 32'(bus.out_data), 32'({14'h3FFF, 14'h1FFF}));

    // Non-reflected sample passes straight through.
    step(1, 0, 1, 0, '0);
    step(0, 0, 0, 1, 28'h5A5_A5A5);

    // Fill to 16, overflow push, push+pop while full, then drain in order.
    for (int i = 0; i < 16; i++) begin
      step(1, i[1] ^ i[0], i[0], 0, '0);
    end
    chk("occ_full", 32'(bus.occupancy), 32'd16);
    step(1, 1, 1, 0, '0);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    step(1, 1, 0, 1, 28'($urandom));
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 28'($urandom));
    end
    chk("occ_drained", 32'(bus.occupancy), 32'd0);

    // Push and pop together while empty, then a bare pop from empty.
    step(1, 1, 0, 1, {14'd77, 14'd300});
    chk("pass_through", 32'(bus.out_data), 32'({14'h3FB3, 14'h3ED4}));
    chk("pass_no_unf", 32'(bus.underflow), 32'd0);
    step(0, 0, 0, 1, 28'h0ABC_DEF);
    chk("unf_set", 32'(bus.underflow), 32'd1);
    chk("unf_data", 32'(bus.out_data), 32'h0ABC_DEF);

    // Reset mid-stream discards stored flags.
    step(1, 1, 0, 0, '0);
    step(1, 1, 1, 0, '0);
    step(1, 1, 0, 0, '0);
    do_reset();
    step(1, 0, 0, 0, '0);
    step(0, 0, 0, 1, 28'h123_4567);
    chk("post_rst_pair", 32'(bus.out_data), 32'h123_4567);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, i[0], 1, 28'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
